// File: rtl/stream_pkt_framer_if.sv
// Stream interface shared by the framer's input and output ports.
// A word moves on a rising edge where tvalid and tready are both high; tvalid/tdata/tlast hold until then.
interface stream_pkt_framer_if #(
    parameter int DW = 32
) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/stream_pkt_framer.sv
// Store-and-forward framer: buffers one packet delimited by an in-band TLAST bit and
// re-emits it behind a {pkt_count, length} header, dropping oversize or stalled packets.
module stream_pkt_framer #(
    parameter int DW            = 32,
    parameter int TLAST_BIT     = DW - 1,
    parameter int MAX_WORDS     = 64,
    parameter int STALL_TIMEOUT = 1000
) (
    input  logic                      aclk,
    input  logic                      areset,
    stream_pkt_framer_if.slave        s00,
    stream_pkt_framer_if.master       m00,
    output logic [15:0]               pkt_count,
    output logic [15:0]               drop_count,
    output logic [1:0]                o_dbg_state
);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DISCARD = 2'd1,
        HDR     = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_ram [MAX_WORDS];
    logic [AW:0]     r_wcnt;
    logic [AW-1:0]   r_rptr;
    logic [15:0]     r_len;
    logic [CW-1:0]   r_idle;
    logic [15:0]     r_pkt_count;
    logic [15:0]     r_drop_count;
    logic            r_s_tready;
    logic            r_m_tvalid;
    logic            r_m_tlast;
    logic [DW-1:0]   r_m_tdata;

    logic            w_accept;
    logic            w_xfer;
    logic            w_tlast_in;
    logic [AW:0]     w_wcnt_inc;
    logic [AW-1:0]   w_rptr_nxt;
    logic [DW-1:0]   w_hdr;

    assign w_accept   = s00.tvalid & r_s_tready;
    assign w_xfer     = r_m_tvalid & m00.tready;
    assign w_tlast_in = s00.tdata[TLAST_BIT];
    assign w_wcnt_inc = r_wcnt + 1'b1;
    assign w_rptr_nxt = r_rptr + 1'b1;

    always_comb begin
        w_hdr        = '0;
        w_hdr[31:0]  = {r_pkt_count, 16'(w_wcnt_inc)};
    end

    // Payload store; only FILL writes, DISCARD words are thrown away.
    always_ff @(posedge aclk) begin
        if (w_accept && (r_state == FILL)) begin
            r_ram[r_wcnt[AW-1:0]] <= s00.tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= FILL;
            r_wcnt       <= '0;
            r_rptr       <= '0;
            r_len        <= '0;
            r_idle       <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_s_tready   <= 1'b1;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_tdata    <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_idle <= '0;
                        if (w_tlast_in) begin
                            r_len      <= 16'(w_wcnt_inc);
                            r_m_tdata  <= w_hdr;
                            r_m_tvalid <= 1'b1;
                            r_m_tlast  <= 1'b0;
                            r_s_tready <= 1'b0;
                            r_state    <= HDR;
                        end else if (r_wcnt == (AW+1)'(MAX_WORDS - 1)) begin
                            r_state <= DISCARD;
                        end else begin
                            r_wcnt <= w_wcnt_inc;
                        end
                    end else if (r_wcnt != '0) begin
                        // Partial packet stalled too long: drop it so no truncated frame escapes.
                        if (r_idle == CW'(STALL_TIMEOUT - 1)) begin
                            r_idle <= '0;
                            r_wcnt <= '0;
                            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
                        end else begin
                            r_idle <= r_idle + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (w_accept && w_tlast_in) begin
                        r_wcnt  <= '0;
                        r_state <= FILL;
                        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        r_rptr    <= '0;
                        r_m_tdata <= r_ram[{AW{1'b0}}];
                        r_m_tlast <= (r_len == 16'd1);
                        r_state   <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_xfer) begin
                        if (r_m_tlast) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                            r_wcnt      <= '0;
                            r_m_tvalid  <= 1'b0;
                            r_m_tlast   <= 1'b0;
                            r_m_tdata   <= '0;
                            r_s_tready  <= 1'b1;
                            r_state     <= FILL;
                        end else begin
                            r_rptr    <= w_rptr_nxt;
                            r_m_tdata <= r_ram[w_rptr_nxt];
                            r_m_tlast <= (16'(w_rptr_nxt) == (r_len - 16'd1));
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign s00.tready  = r_s_tready;
    assign m00.tvalid  = r_m_tvalid;
    assign m00.tdata   = r_m_tdata;
    assign m00.tlast   = r_m_tlast;
    assign pkt_count   = r_pkt_count;
    assign drop_count  = r_drop_count;
    assign o_dbg_state = r_state;
endmodule

// File: doc/stream_pkt_framer.md
# stream_pkt_framer

Store-and-forward packet framer that sits directly downstream of the two-input stream multiplexer's output port. It accepts the multiplexer's tvalid/tready/tdata stream, where packet end is flagged by an in-band TLAST bit. It buffers one complete packet and re-emits it with a prepended header word carrying length and sequence number, plus an explicit out-of-band tlast. It discards oversize and stalled partial packets and counts them, so a consumer never sees a truncated frame.

## Interface
Parameters:
- DW, 32: tdata width; must be >= 32.
- TLAST_BIT, DW-1: in-band end-of-packet bit in s00_tdata.
- MAX_WORDS, 64: payload buffer depth; power of 2, <= 65535.
- STALL_TIMEOUT, 1000: idle cycles with a partial packet before it is discarded; >= 1.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  synchronous, active-high reset.
- s00_tvalid  in  1  input word valid (from multiplexer m00_tvalid).
- s00_tready  out  1  input accept (to multiplexer m00_tready).
- s00_tdata  in  DW  input word, TLAST at TLAST_BIT.
- m00_tvalid  out  1  output word valid.
- m00_tready  in  1  downstream accept.
- m00_tdata  out  DW  header or payload word.
- m00_tlast  out  1  high on the final payload word only.
- pkt_count  out  16  packets fully emitted; wraps.
- drop_count  out  16  packets discarded; saturates at 16'hFFFF.

## Operation
- Input handshake: a word is accepted when s00_tvalid & s00_tready. Output handshake: a word transfers when m00_tvalid & m00_tready.
- Internal state: buffer ram[0:MAX_WORDS-1]; write count wcnt (0..MAX_WORDS); read pointer rptr; idle counter.
- FSM states:
  - FILL: s00_tready=1. Each accepted word is written to ram[wcnt] and wcnt increments.
    - Accepted word with TLAST bit set, and wcnt+1 <= MAX_WORDS: latch L=wcnt+1, go HDR.
    - Accepted word without TLAST at wcnt==MAX_WORDS-1 (buffer now full): go DISCARD.
  - DISCARD: s00_tready=1. Words are accepted and dropped.
    - Accepted word with TLAST set: drop_count++, wcnt=0, go FILL.
  - HDR: s00_tready=0, m00_tvalid=1, m00_tdata={zeros, pkt_count[15:0], L[15:0]}, m00_tlast=0.
    - On transfer: rptr=0, go PAYLOAD.
  - PAYLOAD: s00_tready=0, m00_tvalid=1, m00_tdata=ram[rptr] unmodified (TLAST bit retained), m00_tlast=(rptr==L-1).
    - On transfer: rptr++.
    - On transfer of the last word: pkt_count++ (wraps), wcnt=0, go FILL.
- Stall discard: in FILL with wcnt>0, the idle counter increments on every cycle without an accept and clears on each accept.
  - When the counter reaches STALL_TIMEOUT: drop_count++, wcnt=0, counter cleared, stay in FILL.
  - In DISCARD, no timeout applies; the block waits for TLAST.
- Single-word packet (TLAST on the first word): L=1; header then one payload word with m00_tlast=1.
- Packet of exactly MAX_WORDS words with TLAST on the last word is legal. A word with TLAST arriving when wcnt==MAX_WORDS cannot occur, because FILL exits to DISCARD first.
- drop_count at 16'hFFFF stays at 16'hFFFF. pkt_count 16'hFFFF increments to 0.

## Timing
- Reset: state FILL, wcnt=0, rptr=0, idle counter=0, s00_tready=1, m00_tvalid=0, m00_tlast=0, m00_tdata=0, pkt_count=0, drop_count=0. A partial or queued packet is lost silently and not counted.
- Reset asserted mid-PAYLOAD: m00_tvalid=0 on the cycle after reset is sampled. Downstream sees the frame truncated without tlast; this is acceptable only under reset.
- s00_tready and m00_tvalid are decoded from registered state, with no combinational path from tvalid or tready.
- Latency: TLAST word accepted at edge N; the header is valid from edge N (visible cycle N+1). The first payload word follows on the cycle after header transfer.
- Throughput: one word per cycle in FILL, DISCARD and PAYLOAD while the handshake holds. The only overhead is one header cycle per packet.
- m00_tdata and m00_tlast are stable while m00_tvalid=1 and m00_tready=0.
- s00_tvalid presented during HDR or PAYLOAD is not accepted. The upstream FWFT FIFO holds the word.

## Test plan
- Reset, then a 4-word packet 0x1..0x3, 0x80000004 with m00_tready=1 -> header 0x00000004, then the 4 words with m00_tlast only on 0x80000004; pkt_count=1.
- Second 1-word packet 0x8000ABCD -> header 0x00010001, then 0x8000ABCD with m00_tlast=1; pkt_count=2.
- MAX_WORDS+3 words, TLAST on the last -> nothing emitted, drop_count=1, s00_tready=1 throughout. A following 2-word packet emits with header 0x00000002.
- 3 words then s00_tvalid=0 for STALL_TIMEOUT cycles -> drop_count=1, no output. A following packet's header length counts only its own words.
- Random m00_tready backpressure (50%) during a 64-word packet -> all 65 words are delivered in order; data is held stable while stalled; s00_tready=0 until the last transfer.
- Force drop_count to 16'hFFFF via 65535 oversize packets (or a bench backdoor), then one more -> stays 16'hFFFF.
